// File: rtl/riscv_pkg.sv
// Shared RISC-V multicycle datapath definitions: opcodes, reset defaults,
// instruction field positions and the fetch-capture state encoding.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_J     = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    typedef enum logic [0:0] {
        CAP_IDLE = 1'b0,
        CAP_WAIT = 1'b1
    } cap_state_e;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: load enable, JALR-masked target,
// word-aligned PC value and misalignment detect.
module pc_next_logic
    import riscv_pkg::*;
(
    input  logic        PCWrite,
    input  logic        Branch,
    input  logic        Branch_NE,
    input  logic        PCSrc,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    output logic        pc_en,
    output logic [31:0] target,
    output logic [31:0] pc_aligned,
    output logic        target_misaligned
);

    // Enable, target mux and alignment; bit 0 of ALUOut is dropped for JALR.
    always_comb begin
        pc_en = PCWrite | (Branch & zero) | (Branch_NE & ~zero);
        if (PCSrc) begin
            target = alu_out & 32'hFFFF_FFFE;
        end else begin
            target = alu_result;
        end
        pc_aligned        = {target[31:2], 2'b00};
        target_misaligned = ~is_word_aligned(target);
    end

endmodule

// File: rtl/pc_ir_unit.sv
// PC / old-PC / IR / MDR register block of the multicycle datapath with a
// latency-tolerant instruction capture FSM, fetch counter and misalign flag.
module pc_ir_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        Branch,
    input  logic        Branch_NE,
    input  logic        PCSrc,
    input  logic        IRWrite,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [31:0] mdr,
    output logic        fetch_pending,
    output logic        misaligned,
    output logic [31:0] bad_pc,
    output logic [31:0] fetch_count
);

    logic        pc_en_s;
    logic [31:0] target_s;
    logic [31:0] pc_aligned_s;
    logic        target_misaligned_s;

    cap_state_e  state_r;
    cap_state_e  state_next_s;
    logic        capture_s;
    logic        mdr_load_s;

    logic [31:0] pc_r;
    logic [31:0] old_pc_r;
    logic [31:0] instr_r;
    logic [31:0] mdr_r;
    logic        misaligned_r;
    logic [31:0] bad_pc_r;
    logic [31:0] fetch_count_r;

    pc_next_logic u_pc_next (
        .PCWrite           (PCWrite),
        .Branch            (Branch),
        .Branch_NE         (Branch_NE),
        .PCSrc             (PCSrc),
        .zero              (zero),
        .alu_result        (alu_result),
        .alu_out           (alu_out),
        .pc_en             (pc_en_s),
        .target            (target_s),
        .pc_aligned        (pc_aligned_s),
        .target_misaligned (target_misaligned_s)
    );

    // Capture FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= CAP_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture FSM next state; a repeated IRWrite in WAIT simply stays in WAIT.
    always_comb begin
        state_next_s = CAP_IDLE;
        case (state_r)
            CAP_IDLE: begin
                if (IRWrite && !mem_valid) begin
                    state_next_s = CAP_WAIT;
                end else begin
                    state_next_s = CAP_IDLE;
                end
            end
            CAP_WAIT: begin
                if (mem_valid) begin
                    state_next_s = CAP_IDLE;
                end else begin
                    state_next_s = CAP_WAIT;
                end
            end
            default: state_next_s = CAP_IDLE;
        endcase
    end

    // Capture FSM outputs: memory data goes to IR when a fetch is open, else to MDR.
    always_comb begin
        capture_s     = 1'b0;
        fetch_pending = 1'b0;
        case (state_r)
            CAP_IDLE: begin
                capture_s     = mem_valid & IRWrite;
                fetch_pending = 1'b0;
            end
            CAP_WAIT: begin
                capture_s     = mem_valid;
                fetch_pending = 1'b1;
            end
            default: begin
                capture_s     = 1'b0;
                fetch_pending = 1'b0;
            end
        endcase
        mdr_load_s = mem_valid & ~capture_s;
    end

    // Datapath registers; old_pc takes the pre-update PC when IRWrite coincides with a PC load.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            old_pc_r      <= RESET_PC;
            instr_r       <= NOP_INSTR;
            mdr_r         <= 32'h0000_0000;
            misaligned_r  <= 1'b0;
            bad_pc_r      <= 32'h0000_0000;
            fetch_count_r <= 32'h0000_0000;
        end else begin
            if (pc_en_s) begin
                pc_r <= pc_aligned_s;
            end
            if (pc_en_s && target_misaligned_s && !misaligned_r) begin
                misaligned_r <= 1'b1;
                bad_pc_r     <= target_s;
            end
            if (IRWrite) begin
                old_pc_r <= pc_r;
            end
            if (capture_s) begin
                instr_r       <= mem_rdata;
                fetch_count_r <= fetch_count_r + 32'd1;
            end
            if (mdr_load_s) begin
                mdr_r <= mem_rdata;
            end
        end
    end

    assign pc          = pc_r;
    assign old_pc      = old_pc_r;
    assign instr       = instr_r;
    assign mdr         = mdr_r;
    assign misaligned  = misaligned_r;
    assign bad_pc      = bad_pc_r;
    assign fetch_count = fetch_count_r;

    assign opcode = instr_r[OPCODE_MSB:OPCODE_LSB];
    assign rd     = instr_r[RD_MSB:RD_LSB];
    assign funct3 = instr_r[FUNCT3_MSB:FUNCT3_LSB];
    assign rs1    = instr_r[RS1_MSB:RS1_LSB];
    assign rs2    = instr_r[RS2_MSB:RS2_LSB];
    assign funct7 = instr_r[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_pc_ir_unit.sv
// Scoreboard bench for pc_ir_unit: directed scenarios plus random stimulus
// against an architectural reference model.
module tb_pc_ir_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, Branch, Branch_NE, PCSrc, IRWrite, zero, mem_valid;
    logic [31:0] alu_result, alu_out, mem_rdata;
    logic [31:0] pc, old_pc, instr, mdr, bad_pc, fetch_count;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        fetch_pending, misaligned;

    always #5 clk = ~clk;

    pc_ir_unit dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .Branch(Branch), .Branch_NE(Branch_NE),
        .PCSrc(PCSrc), .IRWrite(IRWrite), .zero(zero), .alu_result(alu_result),
        .alu_out(alu_out), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .pc(pc), .old_pc(old_pc), .instr(instr), .opcode(opcode), .rd(rd),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7), .mdr(mdr),
        .fetch_pending(fetch_pending), .misaligned(misaligned), .bad_pc(bad_pc),
        .fetch_count(fetch_count)
    );

    typedef struct {
        logic [31:0] pc, old_pc, instr, mdr, bad, cnt;
        logic        pend, mis;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Architectural state of the reference model
    logic [31:0] m_pc, m_old, m_instr, m_mdr, m_bad, m_cnt;
    logic        m_pend, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Apply one clock of the specified behaviour to the model.
    task automatic model_step();
        logic        en, take;
        logic [31:0] tgt;
        if (rst) begin
            m_pc = 32'h0040_0000; m_old = 32'h0040_0000; m_instr = 32'h0000_0013;
            m_mdr = 0; m_pend = 0; m_mis = 0; m_bad = 0; m_cnt = 0;
        end else begin
            en  = PCWrite || (Branch && zero) || (Branch_NE && !zero);
            tgt = PCSrc ? (alu_out - (alu_out % 2)) : alu_result;
            if (IRWrite) m_old = m_pc;
            if (en) begin
                m_pc = tgt - (tgt % 4);
                if ((tgt % 4) != 0 && !m_mis) begin
                    m_mis = 1;
                    m_bad = tgt;
                end
            end
            take = mem_valid && (IRWrite || m_pend);
            if (take) begin
                m_instr = mem_rdata;
                m_cnt   = m_cnt + 1;
                m_pend  = 0;
            end else if (IRWrite) begin
                m_pend = 1;
            end
            if (mem_valid && !take) m_mdr = mem_rdata;
        end
    endtask

    // Inputs are already set at a negedge; model the edge, queue the expectation, move on.
    task automatic tick();
        exp_t e;
        model_step();
        e.pc = m_pc; e.old_pc = m_old; e.instr = m_instr; e.mdr = m_mdr;
        e.bad = m_bad; e.cnt = m_cnt; e.pend = m_pend; e.mis = m_mis;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic clr();
        PCWrite = 0; Branch = 0; Branch_NE = 0; PCSrc = 0; IRWrite = 0; zero = 0;
        mem_valid = 0; alu_result = 0; alu_out = 0; mem_rdata = 0;
    endtask

    // Monitor: after each active edge, compare DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("old_pc", old_pc, e.old_pc);
                chk("instr", instr, e.instr);
                chk("opcode", {25'd0, opcode}, {25'd0, e.instr[6:0]});
                chk("rd", {27'd0, rd}, {27'd0, e.instr[11:7]});
                chk("funct3", {29'd0, funct3}, {29'd0, e.instr[14:12]});
                chk("rs1", {27'd0, rs1}, {27'd0, e.instr[19:15]});
                chk("rs2", {27'd0, rs2}, {27'd0, e.instr[24:20]});
                chk("funct7", {25'd0, funct7}, {25'd0, e.instr[31:25]});
                chk("mdr", mdr, e.mdr);
                chk("fetch_pending", {31'd0, fetch_pending}, {31'd0, e.pend});
                chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                chk("bad_pc", bad_pc, e.bad);
                chk("fetch_count", fetch_count, e.cnt);
            end
        end
    end

    initial begin
        clr();
        rst = 1;
        @(negedge clk);
        tick(); tick();
        rst = 0;

        // Fetch with PC increment in the same cycle, zero-wait memory
        IRWrite = 1; PCWrite = 1; alu_result = 32'h0040_0004;
        mem_valid = 1; mem_rdata = 32'h00A0_0093;
        tick(); clr();

        // Branches through ALUOut
        PCSrc = 1; alu_out = 32'h0040_0020; Branch = 1; zero = 1; tick();
        alu_out = 32'h0040_0040; zero = 0; tick();
        Branch = 0; Branch_NE = 1; alu_out = 32'h0040_0060; zero = 0; tick();
        clr();

        // Three wait cycles, then data
        IRWrite = 1; tick(); clr();
        tick(); tick();
        mem_valid = 1; mem_rdata = 32'h1234_5037; tick(); clr();
        tick();

        // JALR misalign, then a second misaligned load
        PCWrite = 1; PCSrc = 1; alu_out = 32'h0040_0013; tick();
        alu_out = 32'h0040_0106; tick();
        clr();

        // Reset while waiting, late data lands in MDR
        IRWrite = 1; tick(); clr();
        rst = 1; tick(); rst = 0;
        mem_valid = 1; mem_rdata = 32'hDEAD_BEEF; tick(); clr();
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 39) == 0);
            PCWrite    = ($urandom_range(0, 3) == 0);
            Branch     = ($urandom_range(0, 3) == 0);
            Branch_NE  = ($urandom_range(0, 3) == 0);
            PCSrc      = $urandom_range(0, 1);
            zero       = $urandom_range(0, 1);
            IRWrite    = ($urandom_range(0, 2) == 0);
            mem_valid  = $urandom_range(0, 1);
            mem_rdata  = $urandom;
            alu_result = $urandom;
            alu_out    = $urandom;
            if ($urandom_range(0, 7) != 0) alu_result[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) alu_out[1:0] = 2'b00;
            tick();
        end
        rst = 0; clr();
        tick();

        // Counter wrap from a preloaded all-ones value
        force dut.fetch_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count_r;
        m_cnt = 32'hFFFF_FFFF;
        IRWrite = 1; mem_valid = 1; mem_rdata = 32'h0000_0297; tick(); clr();
        tick(); tick();

        @(posedge clk);
        #2;
        chk("queue_drain", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
